// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with valid/ready load handshake,
// bit-valid qualifier, last-bit marker and downstream shift stall.
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             accept;

    assign at_last = (state == SHIFT) && (cnt == LAST_CNT);

    // Ready in the final bit only when that bit actually leaves this edge,
    // which is what lets back-to-back words stream without a gap cycle.
    assign load_ready = clear && ((state == IDLE) || (at_last && shift_en));
    assign accept     = load_valid && load_ready;

    assign busy       = (state == SHIFT);
    assign sout_valid = busy;
    assign last       = at_last;
    assign sout       = busy ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 1'b0;

    always_ff @(posedge clk) begin
        if (!clear) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            state <= SHIFT;
            sreg  <= d;
            cnt   <= '0;
        end else if (state == SHIFT && shift_en) begin
            if (cnt == LAST_CNT) begin
                state <= IDLE;
                sreg  <= '0;
                cnt   <= '0;
            end else begin
                // Shift toward the output end, zero-filling behind the data.
                if (MSB_FIRST)
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                else
                    sreg <= {1'b0, sreg[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed self-checking bench for piso_shift_tx; an MSB-first and an
// LSB-first instance share the same stimulus.
module tb_piso_shift_tx;

    logic       clk;
    logic       clear;
    logic [3:0] d;
    logic       load_valid;
    logic       shift_en;

    logic m_ready, m_sout, m_valid, m_last, m_busy;
    logic l_ready, l_sout, l_valid, l_last, l_busy;

    int checks;
    int errors;

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .clear      (clear),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .shift_en   (shift_en),
        .sout       (m_sout),
        .sout_valid (m_valid),
        .last       (m_last),
        .busy       (m_busy)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .clear      (clear),
        .d          (d),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .shift_en   (shift_en),
        .sout       (l_sout),
        .sout_valid (l_valid),
        .last       (l_last),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive inputs right after an edge and let combinational outputs settle.
    task automatic applyStimulus(input logic clr, input logic [3:0] data,
                                 input logic lv, input logic en);
        clear      = clr;
        d          = data;
        load_valid = lv;
        shift_en   = en;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string tag, input bit use_l, input logic exp_sout,
                            input logic exp_valid, input logic exp_last);
        if (use_l) begin
            checkOutput({tag, "_sout"},  l_sout,  exp_sout);
            checkOutput({tag, "_valid"}, l_valid, exp_valid);
            checkOutput({tag, "_last"},  l_last,  exp_last);
            checkOutput({tag, "_busy"},  l_busy,  exp_valid);
        end else begin
            checkOutput({tag, "_sout"},  m_sout,  exp_sout);
            checkOutput({tag, "_valid"}, m_valid, exp_valid);
            checkOutput({tag, "_last"},  m_last,  exp_last);
            checkOutput({tag, "_busy"},  m_busy,  exp_valid);
        end
    endtask

    // Load one word from IDLE and check its four bits; seq[3] is the first bit.
    task automatic runWord(input string tag, input bit use_l, input logic [3:0] word,
                           input logic [3:0] seq);
        applyStimulus(1'b1, word, 1'b1, 1'b1);
        checkOutput({tag, "_rdy_idle"}, use_l ? l_ready : m_ready, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
            checkBit($sformatf("%s_b%0d", tag, i), use_l, seq[3-i], 1'b1, (i == 3));
            tick();
        end
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkBit({tag, "_end"}, use_l, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_rdy_end"}, use_l ? l_ready : m_ready, 1'b1);
    endtask

    logic [7:0] seq8;
    logic [6:0] stall_sout;
    logic [6:0] stall_en;

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] starting piso_shift_tx bench");

        // Reset state
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
        tick();
        tick();
        checkBit("rst_m", 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("rst_l", 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_rdy_m", m_ready, 1'b0);
        checkOutput("rst_rdy_l", l_ready, 1'b0);

        // Single word, MSB first
        runWord("w0011", 1'b0, 4'b0011, 4'b0011);

        // Back-to-back: 0111 then 1011 presented during the last bit
        seq8 = 8'b0111_1011;
        applyStimulus(1'b1, 4'b0111, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
                checkOutput("b2b_rdy_last", m_ready, 1'b1);
            end else begin
                applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
                if (i < 3) checkOutput($sformatf("b2b_rdy%0d", i), m_ready, 1'b0);
            end
            checkBit($sformatf("b2b_b%0d", i), 1'b0, seq8[7-i], 1'b1, (i == 3 || i == 7));
            tick();
        end
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkBit("b2b_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // Stall: 1001 with shift_en low for 3 cycles while the 2nd bit is out
        stall_sout = 7'b1000001;
        stall_en   = 7'b1000111;
        applyStimulus(1'b1, 4'b1001, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0, stall_en[6-i]);
            checkBit($sformatf("stall_w%0d", i), 1'b0, stall_sout[6-i], 1'b1, (i == 6));
            checkOutput($sformatf("stall_rdy%0d", i), m_ready, (i == 6));
            tick();
        end
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkBit("stall_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // LSB-first instance
        runWord("lsb0001", 1'b1, 4'b0001, 4'b1000);
        runWord("lsb1110", 1'b1, 4'b1110, 4'b0111);

        // Reset mid-word aborts the remaining bits
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkBit("abort_b0", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
        checkBit("abort_b1", 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("abort_rdy_clr", m_ready, 1'b0);
        tick();
        checkBit("abort_after", 1'b0, 1'b0, 1'b0, 1'b0);
        runWord("post_abort", 1'b0, 4'b0001, 4'b0001);

        // Load attempt while busy is held off until the last bit
        seq8 = 8'b0101_1010;
        applyStimulus(1'b1, 4'b0101, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i >= 1 && i <= 3) begin
                applyStimulus(1'b1, 4'b1010, 1'b1, 1'b1);
                checkOutput($sformatf("busy_rdy%0d", i), m_ready, (i == 3));
            end else begin
                applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
            end
            checkBit($sformatf("busy_b%0d", i), 1'b0, seq8[7-i], 1'b1, (i == 3 || i == 7));
            tick();
        end
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        checkBit("busy_end", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
